// File: rtl/movimento_pkg.sv
// Shared types and constants for the on-screen object motion path.
// Also imported by the drawing and collision blocks.
package movimento_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } estado_t;

  localparam logic MODO_MANUAL = 1'b0;
  localparam logic MODO_QUICA  = 1'b1;

  localparam int H_RES_PADRAO    = 640;
  localparam int V_RES_PADRAO    = 480;
  localparam int OBJ_SIZE_PADRAO = 50;

  localparam logic [3:0] PASSO_00 = 4'd1;
  localparam logic [3:0] PASSO_01 = 4'd2;
  localparam logic [3:0] PASSO_10 = 4'd4;
  localparam logic [3:0] PASSO_11 = 4'd8;

  function automatic logic [3:0] passo(input logic [1:0] sel);
    logic [3:0] p;
    p = PASSO_00;
    unique case (sel)
      2'b00: p = PASSO_00;
      2'b01: p = PASSO_01;
      2'b10: p = PASSO_10;
      2'b11: p = PASSO_11;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sincroniza_entradas.sv
// Multi-stage synchronizer for asynchronous board inputs.
// Resets every stage to the inactive level of each bit.
module sincroniza_entradas #(
  parameter int         STAGES  = 2,
  parameter int         W       = 7,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RST_VAL;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/controlador_movimento.sv
// Frame-synchronous object position controller (manual keys or bounce).
// New position is committed once per frame during vertical blanking.
module controlador_movimento
  import movimento_pkg::*;
#(
  parameter int H_RES       = H_RES_PADRAO,
  parameter int V_RES       = V_RES_PADRAO,
  parameter int OBJ_SIZE    = OBJ_SIZE_PADRAO,
  parameter int X_INIT      = 150,
  parameter int Y_INIT      = 150,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [3:0] KEY,
  input  logic [2:0] SW,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       update_done,
  output logic       bouncing
);

  localparam logic signed [10:0] X_MAX = 11'(H_RES - OBJ_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(V_RES - OBJ_SIZE);

  logic [6:0] sync_c;
  logic [3:0] key_s;
  logic [2:0] sw_s;

  sincroniza_entradas #(
    .STAGES (SYNC_STAGES),
    .W      (7),
    .RST_VAL({3'b000, 4'hF})
  ) u_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  ({SW, KEY}),
    .q_o  (sync_c)
  );

  assign key_s = sync_c[3:0];
  assign sw_s  = sync_c[6:4];

  estado_t    state_q;
  logic [9:0] pos_x_q;
  logic [8:0] pos_y_q;
  logic       upd_q;
  logic       bounce_q;
  logic       dir_x_neg_q;
  logic       dir_y_neg_q;

  logic signed [10:0] step_c;
  logic signed [10:0] dx_c;
  logic signed [10:0] dy_c;
  logic signed [10:0] cand_x_c;
  logic signed [10:0] cand_y_c;
  logic [9:0]         pos_x_d;
  logic [8:0]         pos_y_d;
  logic               hit_x_c;
  logic               hit_y_c;
  logic               right_c;
  logic               left_c;
  logic               up_c;
  logic               down_c;

  always_comb begin
    step_c  = signed'({7'd0, passo(sw_s[2:1])});
    right_c = ~key_s[0];
    left_c  = ~key_s[1];
    up_c    = ~key_s[2];
    down_c  = ~key_s[3];
    dx_c    = '0;
    dy_c    = '0;
    if (bounce_q == MODO_QUICA) begin
      dx_c = dir_x_neg_q ? -step_c : step_c;
      dy_c = dir_y_neg_q ? -step_c : step_c;
    end else begin
      if (right_c && !left_c) dx_c = step_c;
      if (left_c && !right_c) dx_c = -step_c;
      if (down_c && !up_c)    dy_c = step_c;
      if (up_c && !down_c)    dy_c = -step_c;
    end
    cand_x_c = signed'({1'b0, pos_x_q}) + dx_c;
    cand_y_c = signed'({2'b00, pos_y_q}) + dy_c;

    // Reaching a limit exactly also counts as a hit so bounce reflects there.
    hit_x_c = 1'b1;
    pos_x_d = '0;
    if (cand_x_c <= 0)          pos_x_d = '0;
    else if (cand_x_c >= X_MAX) pos_x_d = X_MAX[9:0];
    else begin
      pos_x_d = cand_x_c[9:0];
      hit_x_c = 1'b0;
    end

    hit_y_c = 1'b1;
    pos_y_d = '0;
    if (cand_y_c <= 0)          pos_y_d = '0;
    else if (cand_y_c >= Y_MAX) pos_y_d = Y_MAX[8:0];
    else begin
      pos_y_d = cand_y_c[8:0];
      hit_y_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pos_x_q     <= 10'(X_INIT);
      pos_y_q     <= 9'(Y_INIT);
      upd_q       <= 1'b0;
      bounce_q    <= MODO_MANUAL;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            bounce_q <= sw_s[0];
            state_q  <= CALC;
          end
        end
        CALC: begin
          pos_x_q <= pos_x_d;
          pos_y_q <= pos_y_d;
          upd_q   <= 1'b1;
          if (bounce_q == MODO_QUICA) begin
            if (hit_x_c) dir_x_neg_q <= ~dir_x_neg_q;
            if (hit_y_c) dir_y_neg_q <= ~dir_y_neg_q;
          end
          state_q <= COMMIT;
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign update_done = upd_q;
  assign bouncing    = bounce_q;

endmodule

// File: tb/tb_controlador_movimento.sv
// Directed testbench for controlador_movimento.
// Drives on negedge, samples on negedge.
module tb_controlador_movimento;

  logic       clk;
  logic       reset_n;
  logic       frame_tick;
  logic [3:0] KEY;
  logic [2:0] SW;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic       update_done;
  logic       bouncing;

  int checks = 0;
  int errors = 0;

  controlador_movimento dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .KEY        (KEY),
    .SW         (SW),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .update_done(update_done),
    .bouncing   (bouncing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] k, input logic [2:0] s);
    @(negedge clk);
    KEY = k;
    SW  = s;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(output logic upd);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) upd = update_done;
  endtask

  task automatic move(input logic [3:0] k, input logic [2:0] s, input int n);
    logic u;
    set_in(k, s);
    repeat (n) frame(u);
  endtask

  logic u;
  int   cnt;

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    KEY        = 4'hF;
    SW         = 3'b000;
    repeat (4) @(negedge clk);
    check("rst_x", pos_x, 150);
    check("rst_y", pos_y, 150);
    check("rst_upd", update_done, 0);
    check("rst_bnc", bouncing, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_x", pos_x, 150);
    check("idle_upd", update_done, 0);

    set_in(4'b1110, 3'b010);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("lat_n1_x", pos_x, 150);
    check("lat_n1_upd", update_done, 0);
    @(negedge clk);
    check("lat_n2_x", pos_x, 152);
    check("lat_n2_y", pos_y, 150);
    check("lat_n2_upd", update_done, 1);
    @(negedge clk);
    check("lat_n3_upd", update_done, 0);

    set_in(4'b1100, 3'b010);
    frame(u);
    check("opp_lr_x", pos_x, 152);
    check("opp_lr_y", pos_y, 150);
    check("opp_lr_upd", u, 1);
    set_in(4'b0011, 3'b010);
    frame(u);
    check("opp_ud_x", pos_x, 152);
    check("opp_ud_y", pos_y, 150);
    check("opp_ud_upd", u, 1);

    move(4'b1110, 3'b110, 54);
    move(4'b1110, 3'b100, 1);
    check("pre_clamp_x", pos_x, 588);
    frame(u);
    check("clamp_hi1", pos_x, 590);
    frame(u);
    check("clamp_hi2", pos_x, 590);

    move(4'b1101, 3'b110, 73);
    move(4'b1101, 3'b010, 1);
    move(4'b1101, 3'b000, 1);
    check("pre_clamp_lo", pos_x, 3);
    move(4'b1101, 3'b100, 1);
    check("clamp_lo", pos_x, 0);
    check("clamp_lo_y", pos_y, 150);

    move(4'b1110, 3'b110, 73);
    move(4'b1110, 3'b100, 1);
    move(4'b1110, 3'b000, 1);
    move(4'b0111, 3'b110, 34);
    move(4'b0111, 3'b100, 1);
    move(4'b0111, 3'b010, 1);
    move(4'b0111, 3'b000, 1);
    check("pre_corner_x", pos_x, 589);
    check("pre_corner_y", pos_y, 429);
    check("pre_corner_bnc", bouncing, 0);

    set_in(4'hF, 3'b001);
    frame(u);
    check("corner1_x", pos_x, 590);
    check("corner1_y", pos_y, 430);
    check("corner1_bnc", bouncing, 1);
    frame(u);
    check("corner2_x", pos_x, 589);
    check("corner2_y", pos_y, 429);
    frame(u);
    check("corner3_x", pos_x, 588);

    set_in(4'hF, 3'b000);
    frame(u);
    check("man_hold_x", pos_x, 588);
    check("man_hold_y", pos_y, 428);
    check("man_bnc", bouncing, 0);
    set_in(4'hF, 3'b001);
    frame(u);
    check("dir_keep_x", pos_x, 587);
    check("dir_keep_y", pos_y, 427);
    set_in(4'b1110, 3'b001);
    frame(u);
    check("bnc_nokey_x", pos_x, 586);
    check("bnc_nokey_y", pos_y, 426);

    @(negedge clk) frame_tick = 1'b1;
    cnt = 0;
    @(negedge clk) cnt += int'(update_done);
    @(negedge clk) begin
      frame_tick = 1'b0;
      cnt += int'(update_done);
    end
    repeat (5) @(negedge clk) cnt += int'(update_done);
    check("coll_cnt", cnt, 1);
    check("coll_x", pos_x, 585);
    check("coll_y", pos_y, 425);

    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) begin
      frame_tick = 1'b0;
      reset_n    = 1'b0;
    end
    #1;
    check("mid_rst_x", pos_x, 150);
    check("mid_rst_y", pos_y, 150);
    check("mid_rst_bnc", bouncing, 0);
    cnt = 0;
    repeat (3) @(negedge clk) cnt += int'(update_done);
    reset_n = 1'b1;
    repeat (4) @(negedge clk) cnt += int'(update_done);
    check("mid_rst_upd", cnt, 0);
    check("post_rst_x", pos_x, 150);
    check("post_rst_y", pos_y, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
